// File: rtl/stream_frame_monitor.sv
// ---------------------------------------------------------------------------
// stream_frame_monitor
//
// In-line AXI4-Stream stage that sits between the pixel generator and the
// VDMA. Video beats pass through a two-entry registered skid buffer without
// modification. On the input side, the block checks the framing markers
// (tuser = start of frame, tlast = end of line) against the configured
// geometry. It also keeps frame, error and stall status for register readback.
//
// Parameters
//   X_SIZE   words per line; EOL is expected on word X_SIZE-1
//   Y_SIZE   lines per frame; SOF is expected on word 0 of line 0
//   TIMEOUT  consecutive idle (tvalid low) cycles before stall is flagged
//
// Ports
//   out_stream_aclk    clock for all logic
//   periph_resetn      asynchronous active-low reset
//   in_stream_*        upstream AXIS slave (tdata/tkeep/tlast/tuser/tvalid/tready)
//   out_stream_*       downstream AXIS master, fully registered
//   err_clr            one-cycle pulse: clears error counters, stall, idle timer
//   frame_count        frames started, wrapping
//   sof_err_count      missing + unexpected SOF events, saturating
//   eol_err_count      missing + unexpected EOL events, saturating
//   stall              sticky idle-timeout flag
// ---------------------------------------------------------------------------
module stream_frame_monitor #(
  parameter int X_SIZE  = 480,
  parameter int Y_SIZE  = 480,
  parameter int TIMEOUT = 1000
) (
  input  logic        out_stream_aclk,
  input  logic        periph_resetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  input  logic        err_clr,
  output logic [15:0] frame_count,
  output logic [15:0] sof_err_count,
  output logic [15:0] eol_err_count,
  output logic        stall
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  // One spare count above TIMEOUT, so the idle counter saturates past the
  // trigger value. The stall condition is therefore a single-cycle event,
  // and err_clr can clear stall while the input stays idle.
  localparam int IW = $clog2(TIMEOUT + 2);

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
  localparam logic [IW-1:0] IDLE_TRIP = IW'(TIMEOUT);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Skid buffer
  // -------------------------------------------------------------------------
  beat_t in_beat, out_beat, skid_beat;
  logic  out_valid, skid_valid, skid_valid_next, ready_q;
  logic  accept, out_open;

  assign in_beat = '{data: in_stream_tdata, keep: in_stream_tkeep,
                     last: in_stream_tlast, user: in_stream_tuser};

  assign accept   = in_stream_tvalid & ready_q;
  // The output register may load this cycle when it is empty or firing.
  assign out_open = !out_valid | out_stream_tready;

  // NOTE: every signal written in always_comb is assigned a default first,
  // so no path can leave it holding a value (which would infer a latch).
  always_comb begin
    skid_valid_next = skid_valid;
    if (out_open)    skid_valid_next = 1'b0;  // skid drains into the output
    else if (accept) skid_valid_next = 1'b1;  // output stalled: park the beat
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      ready_q    <= 1'b0;
      skid_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_beat   <= '0;
    end else begin
      // tready mirrors the skid state of the next cycle, but is registered.
      ready_q    <= !skid_valid_next;
      skid_valid <= skid_valid_next;
      if (out_open) begin
        if (skid_valid) begin
          out_beat  <= skid_beat;
          out_valid <= 1'b1;
        end else if (accept) begin
          out_beat  <= in_beat;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  // NOTE: the skid payload needs no reset. skid_valid qualifies it, and it
  // reaches the outputs only through out_beat, which is reset.
  always_ff @(posedge out_stream_aclk) begin
    if (!out_open && accept) skid_beat <= in_beat;
  end

  assign in_stream_tready  = ready_q;
  assign out_stream_tvalid = out_valid;
  assign out_stream_tdata  = out_beat.data;
  assign out_stream_tkeep  = out_beat.keep;
  assign out_stream_tlast  = out_beat.last;
  assign out_stream_tuser  = out_beat.user;

  // -------------------------------------------------------------------------
  // Framing checker (accepted input beats only)
  // -------------------------------------------------------------------------
  logic [XW-1:0] x, pos_x, x_next;
  logic [YW-1:0] y, pos_y, y_next, y_adv;
  logic          at_origin, at_eol, line_end;
  logic          frame_evt, sof_evt, eol_evt;

  always_comb begin
    // A stray SOF restarts the frame, so it is checked as word 0 of line 0.
    pos_x     = in_stream_tuser ? '0 : x;
    pos_y     = in_stream_tuser ? '0 : y;
    at_origin = (x == '0) && (y == '0);
    at_eol    = (pos_x == X_LAST);
    // A missing EOL and an early EOL both close the line.
    line_end  = at_eol | in_stream_tlast;
    y_adv     = (pos_y == Y_LAST) ? '0 : pos_y + YW'(1);
    x_next    = line_end ? '0 : pos_x + XW'(1);
    y_next    = line_end ? y_adv : pos_y;
    frame_evt = accept & (in_stream_tuser | at_origin);
    sof_evt   = accept & (in_stream_tuser ^ at_origin);
    eol_evt   = accept & (at_eol ^ in_stream_tlast);
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
    end else begin
      if (accept) begin
        x <= x_next;
        y <= y_next;
      end
      if (frame_evt) frame_count <= frame_count + 16'd1;
    end
  end

  // An error event in the same cycle as err_clr wins, so the counter loads 1.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      sof_err_count <= '0;
      eol_err_count <= '0;
    end else begin
      if (sof_evt)      sof_err_count <= err_clr ? 16'd1 : sat_inc(sof_err_count);
      else if (err_clr) sof_err_count <= '0;
      if (eol_evt)      eol_err_count <= err_clr ? 16'd1 : sat_inc(eol_err_count);
      else if (err_clr) eol_err_count <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Stall timer
  // -------------------------------------------------------------------------
  logic [IW-1:0] idle;

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      idle  <= '0;
      stall <= 1'b0;
    end else begin
      if (in_stream_tvalid || err_clr) idle <= '0;
      else if (idle != '1)             idle <= idle + IW'(1);
      // A timeout in the same cycle as err_clr keeps stall set.
      stall <= (idle == IDLE_TRIP) | (stall & !err_clr);
    end
  end

endmodule

// File: tb/tb_stream_frame_monitor.sv
// ---------------------------------------------------------------------------
// tb_stream_frame_monitor
//
// Directed bench for stream_frame_monitor. It uses a reduced geometry
// (8 words x 4 lines, timeout 20) so that full frames stay short.
// A negedge monitor keeps a queue of accepted input beats. It checks every
// output handshake against that queue, and checks that a stalled output
// holds its value. Each scenario task drives its stimulus and compares the
// status outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_stream_frame_monitor;

  localparam int X  = 8;
  localparam int Y  = 4;
  localparam int TO = 20;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_stream_tdata;
  logic [3:0]  in_stream_tkeep;
  logic        in_stream_tlast, in_stream_tuser, in_stream_tvalid, in_stream_tready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid, out_stream_tready;
  logic        err_clr;
  logic [15:0] frame_count, sof_err_count, eol_err_count;
  logic        stall;

  stream_frame_monitor #(.X_SIZE(X), .Y_SIZE(Y), .TIMEOUT(TO)) dut (
    .out_stream_aclk  (clk),
    .periph_resetn    (rst_n),
    .in_stream_tdata  (in_stream_tdata),
    .in_stream_tkeep  (in_stream_tkeep),
    .in_stream_tlast  (in_stream_tlast),
    .in_stream_tuser  (in_stream_tuser),
    .in_stream_tvalid (in_stream_tvalid),
    .in_stream_tready (in_stream_tready),
    .out_stream_tdata (out_stream_tdata),
    .out_stream_tkeep (out_stream_tkeep),
    .out_stream_tlast (out_stream_tlast),
    .out_stream_tuser (out_stream_tuser),
    .out_stream_tvalid(out_stream_tvalid),
    .out_stream_tready(out_stream_tready),
    .err_clr          (err_clr),
    .frame_count      (frame_count),
    .sof_err_count    (sof_err_count),
    .eol_err_count    (eol_err_count),
    .stall            (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          ready_waits  = 0;
  logic [31:0] data_ctr     = 32'h1000_0000;
  logic        rand_ready   = 1'b0;
  logic [37:0] sb[$];

  // Random downstream back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_stream_tready = 1'($urandom_range(0, 1));
  end

  // Ordering and hold monitor. It pops before it pushes, so a beat cannot
  // appear at the output in the same cycle it is accepted.
  logic [37:0] prev_out;
  logic        prev_stalled = 1'b0;
  always @(negedge clk) begin
    logic [37:0] cur, exp_beat;
    if (!rst_n) begin
      sb.delete();
      prev_stalled = 1'b0;
    end else begin
      cur = {out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser};
      if (prev_stalled) begin
        tests_run++;
        if (!out_stream_tvalid || cur !== prev_out) begin
          tests_failed++;
          $display("FAIL hold: valid=%b beat=%h, required valid=1 beat=%h",
                   out_stream_tvalid, cur, prev_out);
        end
      end
      if (out_stream_tvalid && out_stream_tready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL order: beat=%h emitted, required no beat (none pending)", cur);
        end else begin
          exp_beat = sb.pop_front();
          if (cur !== exp_beat) begin
            tests_failed++;
            $display("FAIL order: beat=%h, required %h", cur, exp_beat);
          end
        end
      end
      if (in_stream_tvalid && in_stream_tready)
        sb.push_back({in_stream_tdata, in_stream_tkeep, in_stream_tlast, in_stream_tuser});
      prev_stalled = out_stream_tvalid && !out_stream_tready;
      prev_out     = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic user, input logic last);
    logic got;
    int   n;
    in_stream_tdata  = data_ctr;
    in_stream_tkeep  = data_ctr[3:0] ^ 4'hA;
    in_stream_tuser  = user;
    in_stream_tlast  = last;
    in_stream_tvalid = 1'b1;
    n = 0;
    forever begin
      got = in_stream_tready;
      step();
      if (got) break;
      ready_waits++;
      n++;
      if (n > 200) begin
        tests_run++;
        tests_failed++;
        $display("FAIL accept_timeout: tready=0 for %0d cycles, required 1", n);
        break;
      end
    end
    data_ctr++;
    in_stream_tvalid = 1'b0;
  endtask

  // Sends n correctly framed beats, starting at word x0 of line y0.
  task automatic send_part(input int y0, input int x0, input int n);
    int xx = x0;
    int yy = y0;
    for (int i = 0; i < n; i++) begin
      drive_beat(xx == 0 && yy == 0, xx == X - 1);
      xx++;
      if (xx == X) begin
        xx = 0;
        yy = (yy + 1) % Y;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    out_stream_tready = 1'b1;
    while ((sb.size() != 0 || out_stream_tvalid) && n < 100) begin
      step();
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d beats pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_stream_tdata = '0; in_stream_tkeep = '0; in_stream_tlast = 1'b0;
    in_stream_tuser = 1'b0; in_stream_tvalid = 1'b0;
    out_stream_tready = 1'b1; err_clr = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({in_stream_tready, out_stream_tvalid, out_stream_tdata, out_stream_tkeep,
         out_stream_tlast, out_stream_tuser} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: tready=%b tvalid=%b data=%h, required all 0",
               in_stream_tready, out_stream_tvalid, out_stream_tdata);
    end
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count, stall} !== '0) begin
      tests_failed++;
      $display("FAIL reset_status: f=%0d s=%0d e=%0d st=%b, required 0 0 0 0",
               frame_count, sof_err_count, eol_err_count, stall);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (in_stream_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_release: tready=%b, required 0 before first edge", in_stream_tready);
    end
    step();
    tests_run++;
    if (in_stream_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_first_edge: tready=%b, required 1", in_stream_tready);
    end
  endtask

  task automatic test_always_ready();
    int w0 = ready_waits;
    send_part(0, 0, 2 * X * Y);
    tests_run++;
    if (ready_waits != w0) begin
      tests_failed++;
      $display("FAIL throughput: %0d tready bubbles, required 0", ready_waits - w0);
    end
    drain();
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count} !== {16'd2, 16'd0, 16'd0}) begin
      tests_failed++;
      $display("FAIL always_ready_counts: f=%0d s=%0d e=%0d, required 2 0 0",
               frame_count, sof_err_count, eol_err_count);
    end
  endtask

  task automatic test_random_ready();
    rand_ready = 1'b1;
    send_part(0, 0, 2 * X * Y);
    rand_ready = 1'b0;
    drain();
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count} !== {16'd4, 16'd0, 16'd0}) begin
      tests_failed++;
      $display("FAIL random_ready_counts: f=%0d s=%0d e=%0d, required 4 0 0",
               frame_count, sof_err_count, eol_err_count);
    end
  endtask

  task automatic test_eol_errors();
    // Early EOL on word 3 of line 1; the next beat is word 0 of line 2.
    send_part(0, 0, X + 3);
    drive_beat(1'b0, 1'b1);
    send_part(2, 0, 2 * X);
    send_part(0, 0, X * Y);
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count} !== {16'd6, 16'd0, 16'd1}) begin
      tests_failed++;
      $display("FAIL early_eol: f=%0d s=%0d e=%0d, required 6 0 1",
               frame_count, sof_err_count, eol_err_count);
    end
    // Missing EOL on the last word of line 2; the line still closes.
    send_part(0, 0, 2 * X + X - 1);
    drive_beat(1'b0, 1'b0);
    send_part(3, 0, X);
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count} !== {16'd7, 16'd0, 16'd2}) begin
      tests_failed++;
      $display("FAIL missing_eol: f=%0d s=%0d e=%0d, required 7 0 2",
               frame_count, sof_err_count, eol_err_count);
    end
  endtask

  task automatic test_sof_errors();
    // Stray SOF on word 5 of line 1 starts a new frame at that beat.
    send_part(0, 0, X + 5);
    drive_beat(1'b1, 1'b0);
    send_part(0, 1, X * Y - 1);
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count} !== {16'd9, 16'd1, 16'd2}) begin
      tests_failed++;
      $display("FAIL stray_sof: f=%0d s=%0d e=%0d, required 9 1 2",
               frame_count, sof_err_count, eol_err_count);
    end
    send_part(0, 0, X * Y);
    // SOF and EOL together on word 3: both counters step, and the beat
    // closes line 0 of the restarted frame.
    send_part(0, 0, 3);
    drive_beat(1'b1, 1'b1);
    send_part(1, 0, (Y - 1) * X);
    drain();
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count} !== {16'd12, 16'd2, 16'd3}) begin
      tests_failed++;
      $display("FAIL sof_and_eol: f=%0d s=%0d e=%0d, required 12 2 3",
               frame_count, sof_err_count, eol_err_count);
    end
  endtask

  task automatic test_stall_and_clear();
    send_part(0, 0, X * Y);
    repeat (TO) step();
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_early: stall=%b after %0d idle, required 0", stall, TO);
    end
    step();
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_set: stall=%b, required 1", stall);
    end
    repeat (5) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count, stall} !== {16'd13, 16'd0, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL err_clr: f=%0d s=%0d e=%0d st=%b, required 13 0 0 0",
               frame_count, sof_err_count, eol_err_count, stall);
    end
    // err_clr in the same cycle as the timeout: stall must stay set.
    repeat (TO) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_vs_stall: stall=%b, required 1", stall);
    end
    // err_clr with a missing SOF in the same cycle: sof count loads 1.
    err_clr = 1'b1;
    drive_beat(1'b0, 1'b0);
    err_clr = 1'b0;
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count, stall} !== {16'd14, 16'd1, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL clr_vs_err: f=%0d s=%0d e=%0d st=%b, required 14 1 0 0",
               frame_count, sof_err_count, eol_err_count, stall);
    end
    send_part(0, 1, X * Y - 1);
    drain();
    tests_run++;
    if ({sof_err_count, eol_err_count} !== {16'd1, 16'd0}) begin
      tests_failed++;
      $display("FAIL after_clr_frame: s=%0d e=%0d, required 1 0", sof_err_count, eol_err_count);
    end
  endtask

  task automatic test_reset_mid_line();
    logic [31:0] held;
    send_part(0, 0, X + 2);
    out_stream_tready = 1'b0;
    held = data_ctr - 32'd1;
    drive_beat(1'b0, 1'b0);
    repeat (2) step();
    tests_run++;
    if ({in_stream_tready, out_stream_tvalid, out_stream_tdata} !== {1'b0, 1'b1, held}) begin
      tests_failed++;
      $display("FAIL skid_full: tready=%b valid=%b data=%h, required 0 1 %h",
               in_stream_tready, out_stream_tvalid, out_stream_tdata, held);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_stream_tready, out_stream_tvalid, out_stream_tdata, frame_count, sof_err_count} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: tready=%b valid=%b data=%h f=%0d s=%0d, required all 0",
               in_stream_tready, out_stream_tvalid, out_stream_tdata, frame_count, sof_err_count);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    out_stream_tready = 1'b1;
    send_part(0, 0, X * Y);
    drain();
    tests_run++;
    if ({frame_count, sof_err_count, eol_err_count, stall} !== {16'd1, 16'd0, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL post_reset_frame: f=%0d s=%0d e=%0d st=%b, required 1 0 0 0",
               frame_count, sof_err_count, eol_err_count, stall);
    end
  endtask

  initial begin
    test_reset();
    test_always_ready();
    test_random_ready();
    test_eol_errors();
    test_sof_errors();
    test_stall_and_clear();
    test_reset_mid_line();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
